// File: rtl/dma_reg_pkg.sv
// Shared constants and state encoding for the DMA register-bus initiator.
package dma_reg_pkg;

  localparam int unsigned NUM_DMA_REGS = 4;

  localparam logic [31:0] INTR_OFFSET     = 32'h0;
  localparam logic [31:0] CTRL_OFFSET     = 32'h4;
  localparam logic [31:0] IO_ADDR_OFFSET  = 32'h8;
  localparam logic [31:0] MEM_ADDR_OFFSET = 32'hC;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRdIssue,
    StRdWait,
    StDone
  } dma_state_e;

  function automatic logic [31:0] reg_offset(logic [1:0] idx);
    logic [31:0] off;
    unique case (idx)
      2'd0:    off = INTR_OFFSET;
      2'd1:    off = CTRL_OFFSET;
      2'd2:    off = IO_ADDR_OFFSET;
      default: off = MEM_ADDR_OFFSET;
    endcase
    return off;
  endfunction

endpackage

// File: rtl/dma_reg_master_if.sv
// Register bus between the DMA register initiator and the DMA register slave.
interface dma_reg_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  valid;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output addr, output wr_en, output valid, output wdata, input rdata);
  modport slave  (input addr, input wr_en, input valid, input wdata, output rdata);
endinterface

// File: rtl/dma_reg_master.sv
// Programs the four DMA configuration registers from a one-shot descriptor.
// Define DMA_REG_MASTER_READBACK_EN to read each register back and flag mismatches.
module dma_reg_master
  import dma_reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [31:0] BASE_ADDR  = 32'h400
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_DMA_REGS-1:0] reg_mask,
  input  logic [DATA_WIDTH-1:0]   intr_val,
  input  logic [DATA_WIDTH-1:0]   ctrl_val,
  input  logic [DATA_WIDTH-1:0]   io_addr_val,
  input  logic [DATA_WIDTH-1:0]   mem_addr_val,
  output logic                    busy,
  output logic                    done,
  output logic [NUM_DMA_REGS-1:0] err,
  dma_reg_master_if.master        bus
);

  dma_state_e state_q, state_d;
  logic [NUM_DMA_REGS-1:0]                 mask_q, mask_d;
  logic [NUM_DMA_REGS-1:0][DATA_WIDTH-1:0] vals_q, vals_d;
  logic [1:0]                              idx_q, idx_d;
  logic [2:0]                              nxt;

  // Lowest set mask bit at index >= lo; bit 2 of the result flags "none left".
  function automatic logic [2:0] first_from(logic [NUM_DMA_REGS-1:0] m, logic [2:0] lo);
    logic [2:0] r;
    r = 3'b100;
    for (int i = NUM_DMA_REGS - 1; i >= 0; i--) begin
      if (m[i] && (3'(i) >= lo)) r = {1'b0, 2'(i)};
    end
    return r;
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] reg_addr(logic [1:0] i);
    return ADDR_WIDTH'(BASE_ADDR + reg_offset(i));
  endfunction

`ifdef DMA_REG_MASTER_READBACK_EN
  logic [NUM_DMA_REGS-1:0] err_q, err_d;
  assign err = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^bus.rdata;
  assign err = '0;
`endif

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    vals_d    = vals_q;
    idx_d     = idx_q;
    nxt       = 3'b100;
    busy      = 1'b0;
    done      = 1'b0;
    bus.valid = 1'b0;
    bus.wr_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
`ifdef DMA_REG_MASTER_READBACK_EN
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        done    = (state_q == StDone);
        state_d = StIdle;
        if (start) begin
          mask_d  = reg_mask;
          vals_d  = {mem_addr_val, io_addr_val, ctrl_val, intr_val};
`ifdef DMA_REG_MASTER_READBACK_EN
          err_d   = '0;
`endif
          nxt     = first_from(reg_mask, 3'd0);
          idx_d   = nxt[1:0];
          state_d = nxt[2] ? StDone : StWrite;
        end
      end
      StWrite: begin
        busy      = 1'b1;
        bus.valid = 1'b1;
        bus.wr_en = 1'b1;
        bus.addr  = reg_addr(idx_q);
        bus.wdata = vals_q[idx_q];
        nxt       = first_from(mask_q, {1'b0, idx_q} + 3'd1);
        if (!nxt[2]) begin
          idx_d = nxt[1:0];
        end else begin
`ifdef DMA_REG_MASTER_READBACK_EN
          nxt     = first_from(mask_q, 3'd0);
          idx_d   = nxt[1:0];
          state_d = StRdIssue;
`else
          state_d = StDone;
`endif
        end
      end
`ifdef DMA_REG_MASTER_READBACK_EN
      StRdIssue: begin
        busy      = 1'b1;
        bus.valid = 1'b1;
        bus.addr  = reg_addr(idx_q);
        state_d   = StRdWait;
      end
      StRdWait: begin
        busy = 1'b1;
        // Slave returns read data one cycle after the read beat.
        if (bus.rdata != vals_q[idx_q]) err_d[idx_q] = 1'b1;
        nxt = first_from(mask_q, {1'b0, idx_q} + 3'd1);
        if (nxt[2]) begin
          state_d = StDone;
        end else begin
          idx_d   = nxt[1:0];
          state_d = StRdIssue;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      mask_q  <= '0;
      vals_q  <= '0;
      idx_q   <= '0;
`ifdef DMA_REG_MASTER_READBACK_EN
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      vals_q  <= vals_d;
      idx_q   <= idx_d;
`ifdef DMA_REG_MASTER_READBACK_EN
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_dma_reg_master.sv
// Directed, table-driven bench for dma_reg_master with a registered-read slave model.
module tb_dma_reg_master;

  typedef struct {
    logic [3:0]  mask;
    logic        corrupt;
    logic [3:0]  err_rb;
    int          done_rb;
    int          done_nrb;
    logic [31:0] v0, v1, v2, v3;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

`ifdef DMA_REG_MASTER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  reg_mask = '0;
  logic [31:0] intr_val = '0, ctrl_val = '0, io_addr_val = '0, mem_addr_val = '0;
  logic        busy, done;
  logic [3:0]  err;
  logic        corrupt_rd = 1'b0;
  logic [31:0] mem [4];
  int          tests = 0;
  int          fails = 0;

  dma_reg_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

  dma_reg_master #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BASE_ADDR (32'h400)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .reg_mask    (reg_mask),
    .intr_val    (intr_val),
    .ctrl_val    (ctrl_val),
    .io_addr_val (io_addr_val),
    .mem_addr_val(mem_addr_val),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  // Slave: writes land in mem, reads return registered data; 0x408 optionally corrupted.
  initial bus_if.rdata = '0;
  always @(posedge clk) begin
    if (bus_if.valid && bus_if.wr_en) mem[bus_if.addr[3:2]] <= bus_if.wdata;
    if (bus_if.valid && !bus_if.wr_en)
      bus_if.rdata <= mem[bus_if.addr[3:2]] ^
                      ((corrupt_rd && bus_if.addr == 32'h408) ? 32'h0000_00FF : 32'h0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_desc(input vec_t v);
    reg_mask     = v.mask;
    intr_val     = v.v0;
    ctrl_val     = v.v1;
    io_addr_val  = v.v2;
    mem_addr_val = v.v3;
  endtask

  // Runs one operation; returns at the negedge of the done cycle (inside DONE).
  task automatic run_op(input vec_t v, input int poke_cyc);
    beat_t       got[$];
    beat_t       exp[$];
    logic [31:0] vals[4];
    int          n;
    int          done_cyc;
    logic [3:0]  err_seen;
    bit          zero_ok;
    vals = '{v.v0, v.v1, v.v2, v.v3};
    corrupt_rd = v.corrupt;
    @(posedge clk); #1;
    start = 1'b1;
    drive_desc(v);
    @(posedge clk); #1;
    start = 1'b0;
    done_cyc = -1;
    err_seen = 4'hx;
    zero_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (c == poke_cyc) begin
        start = 1'b1;
        reg_mask = 4'hF;
        intr_val = 32'hDEAD_0000;
        ctrl_val = 32'hDEAD_0001;
        io_addr_val = 32'hDEAD_0002;
        mem_addr_val = 32'hDEAD_0003;
      end else if (c == poke_cyc + 1) begin
        start = 1'b0;
        drive_desc(v);
      end
      @(negedge clk);
      if (c == 1) check("busy_cycle1", 32'(busy), 32'(v.mask != 4'h0));
      if (bus_if.valid) got.push_back('{c, bus_if.wr_en, bus_if.addr, bus_if.wdata});
      else if (bus_if.addr != '0 || bus_if.wdata != '0 || bus_if.wr_en) zero_ok = 1'b0;
      if (done) begin
        done_cyc = c;
        err_seen = err;
        check("busy_at_done", 32'(busy), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (v.mask[i]) begin
        exp.push_back('{n + 1, 1'b1, 32'h400 + 32'(4 * i), vals[i]});
        n++;
      end
    end
    if (RB) begin
      for (int i = 0, k = 0; i < 4; i++) begin
        if (v.mask[i]) begin
          exp.push_back('{n + 1 + 2 * k, 1'b0, 32'h400 + 32'(4 * i), 32'h0});
          k++;
        end
      end
    end
    check("done_cycle", 32'(done_cyc), RB ? 32'(v.done_rb) : 32'(v.done_nrb));
    check("err_at_done", 32'(err_seen), RB ? 32'(v.err_rb) : 32'h0);
    check("beat_count", 32'(got.size()), 32'(exp.size()));
    check("idle_bus_zero", 32'(zero_ok), 32'd1);
    for (int i = 0; i < got.size() && i < exp.size(); i++) begin
      check("beat_cycle", 32'(got[i].cyc), 32'(exp[i].cyc));
      check("beat_wr_en", 32'(got[i].wr), 32'(exp[i].wr));
      check("beat_addr", got[i].addr, exp[i].addr);
      if (exp[i].wr) check("beat_wdata", got[i].data, exp[i].data);
    end
  endtask

  initial begin
    vec_t vecs[7];
    vec_t v;
    bit   saw;
    int   dc;
    vecs[0] = '{4'hF, 1'b0, 4'h0, 13, 5, 32'd11, 32'd22, 32'd33, 32'd44};
    vecs[1] = '{4'hA, 1'b0, 4'h0, 7, 3, 32'hA0, 32'hA1, 32'hA2, 32'hA3};
    vecs[2] = '{4'h0, 1'b0, 4'h0, 1, 1, 32'h1, 32'h2, 32'h3, 32'h4};
    vecs[3] = '{4'hF, 1'b1, 4'h4, 13, 5, 32'h100, 32'h200, 32'h300, 32'h400};
    vecs[4] = '{4'h1, 1'b0, 4'h0, 4, 2, 32'hCAFE, 32'h0, 32'h0, 32'h0};
    vecs[5] = '{4'h8, 1'b0, 4'h0, 4, 2, 32'h0, 32'h0, 32'h0, 32'hBEEF};
    vecs[6] = '{4'h4, 1'b1, 4'h4, 4, 2, 32'h0, 32'h0, 32'h5555, 32'h0};

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_valid", 32'(bus_if.valid), 32'd0);
    check("rst_wr_en", 32'(bus_if.wr_en), 32'd0);
    check("rst_addr", bus_if.addr, 32'h0);
    check("rst_wdata", bus_if.wdata, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run_op(vecs[i], -5);

    // Start pulsed in cycle 2 while busy must not disturb the 4'b1010 sequence.
    run_op(vecs[1], 2);

    // Corrupt op, then start held in the DONE cycle: next op's write follows immediately.
    run_op(vecs[3], -5);
    v = '{4'h4, 1'b0, 4'h0, 4, 2, 32'h0, 32'h0, 32'h7777, 32'h0};
    start = 1'b1;
    drive_desc(v);
    corrupt_rd = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_valid", 32'(bus_if.valid), 32'd1);
    check("b2b_wr_en", 32'(bus_if.wr_en), 32'd1);
    check("b2b_addr", bus_if.addr, 32'h408);
    check("b2b_wdata", bus_if.wdata, 32'h7777);
    check("b2b_err_cleared", 32'(err), 32'h0);
    dc = -1;
    for (int c = 1; c <= 30; c++) begin
      if (done) begin
        dc = c;
        check("b2b_err_done", 32'(err), 32'h0);
        break;
      end
      @(negedge clk);
    end
    check("b2b_done_cycle", 32'(dc), RB ? 32'd4 : 32'd2);

    // Reset during the third write beat abandons the operation.
    @(posedge clk); #1;
    start = 1'b1;
    drive_desc(vecs[0]);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("pre_rst_valid", 32'(bus_if.valid), 32'd1);
    check("pre_rst_addr", bus_if.addr, 32'h408);
    reset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus_if.valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_addr", bus_if.addr, 32'h0);
    saw = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done || bus_if.valid) saw = 1'b1;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done || bus_if.valid) saw = 1'b1;
    end
    check("no_done_after_rst", 32'(saw), 32'd0);
    run_op(vecs[0], -5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
